// File: rtl/chk_pkg.sv
// Constants shared between the result checker and the stim block.
package chk_pkg;
    localparam logic [4:0]  SC_CMD_IDLE    = 5'b00000;
    localparam logic [4:0]  SC_CMD_BITMASK = 5'b00001;

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_WR_REC = 2'd1;
    localparam logic [1:0]  ST_WR_SUM = 2'd2;
    localparam logic [1:0]  ST_DONE   = 2'd3;

    localparam logic [15:0] SUM_MARKER = 16'hFFFF;
    localparam int          REC_WORDS  = 4;
endpackage

// File: rtl/check_if.sv
// FIFO pop, stim control and Avalon write-master signals of the checker.
interface check_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int STF_WIDTH  = 24,
    parameter int CHF_WIDTH  = STF_WIDTH + ADDR_WIDTH,
    parameter int SCC_WIDTH  = 5,
    parameter int SCD_WIDTH  = 24
);
    logic [CHF_WIDTH-1:0]  cfifo_data;
    logic                  cfifo_rdreq;
    logic                  cfifo_rdempty;
    logic [STF_WIDTH-1:0]  rfifo_data;
    logic                  rfifo_rdreq;
    logic                  rfifo_rdempty;
    logic [SCC_WIDTH-1:0]  sc_cmd;
    logic [SCD_WIDTH-1:0]  sc_data;
    logic                  sc_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [BE_WIDTH-1:0]   mem_byteenable;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_writedata;
    logic                  mem_waitrequest;

    modport master (
        input  cfifo_data, cfifo_rdempty, rfifo_data, rfifo_rdempty,
               sc_cmd, sc_data, mem_waitrequest,
        output cfifo_rdreq, rfifo_rdreq, sc_ready,
               mem_address, mem_byteenable, mem_write, mem_writedata
    );

    modport slave (
        output cfifo_data, cfifo_rdempty, rfifo_data, rfifo_rdempty,
               sc_cmd, sc_data, mem_waitrequest,
        input  cfifo_rdreq, rfifo_rdreq, sc_ready,
               mem_address, mem_byteenable, mem_write, mem_writedata
    );
endinterface

// File: rtl/check_rec_fmt.sv
// Selects the memory word for the current record/summary word index.
module rec_fmt
    import chk_pkg::*;
(
    input  logic [1:0]  state_i,
    input  logic [1:0]  w_i,
    input  logic        fail_i,
    input  logic [23:0] act_i,
    input  logic [19:0] vaddr_i,
    input  logic [15:0] fail_cnt_i,
    input  logic [15:0] pass_cnt_i,
    output logic [15:0] wdata_o
);
    always_comb begin
        wdata_o = '0;
        if (state_i == ST_WR_REC) begin
            case (w_i)
                2'd0:    wdata_o = {fail_i, 7'b0, act_i[23:16]};
                2'd1:    wdata_o = act_i[15:0];
                2'd2:    wdata_o = {12'b0, vaddr_i[19:16]};
                default: wdata_o = vaddr_i[15:0];
            endcase
        end else if (state_i == ST_WR_SUM) begin
            case (w_i)
                2'd0:    wdata_o = SUM_MARKER;
                2'd1:    wdata_o = fail_cnt_i;
                2'd2:    wdata_o = pass_cnt_i;
                default: wdata_o = '0;
            endcase
        end
    end
endmodule

// File: rtl/check.sv
// Result checker: compares expected/actual vector pairs under a bitmask and
// logs a 4-word record per vector, then a summary record, to external memory.
//   state     | meaning
//   ST_IDLE   | waiting for a FIFO pair, or for stim_done with both FIFOs empty
//   ST_WR_REC | writing the 4-word result record of the latched pair
//   ST_WR_SUM | writing the 4-word summary record
//   ST_DONE   | summary written; leaves when stim_done drops
module check
    import chk_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int STF_WIDTH  = 24,
    parameter int CHF_WIDTH  = STF_WIDTH + ADDR_WIDTH,
    parameter int SCC_WIDTH  = 5,
    parameter int SCD_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RES_BASE = 'h80000
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    stim_done,
    output logic    done,
    check_if.master bus
);
    localparam logic [1:0] LAST_W = 2'(REC_WORDS - 1);

    logic [1:0]            state_q, state_d;
    logic [1:0]            w_q, w_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [STF_WIDTH-1:0]  act_q, act_d;
    logic [STF_WIDTH-1:0]  mask_q, mask_d, mask_eff;
    logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d;
    logic                  fail_q, fail_d;
    logic [CNT_WIDTH-1:0]  pass_q, pass_d, fcnt_q, fcnt_d;
    logic                  pop, accept, mask_ld, both_empty;

    // A mask written in the pop cycle already applies to that compare.
    assign mask_ld    = (bus.sc_cmd == SC_CMD_BITMASK);
    assign mask_eff   = mask_ld ? bus.sc_data : mask_q;
    assign both_empty = bus.cfifo_rdempty && bus.rfifo_rdempty;
    assign pop        = reset_n && (state_q == ST_IDLE) && !bus.cfifo_rdempty && !bus.rfifo_rdempty;
    assign accept     = bus.mem_write && !bus.mem_waitrequest;

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        wr_ptr_d = wr_ptr_q;
        act_d    = act_q;
        vaddr_d  = vaddr_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        fcnt_d   = fcnt_q;
        mask_d   = mask_eff;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    act_d   = bus.rfifo_data;
                    vaddr_d = bus.cfifo_data[ADDR_WIDTH-1:0];
                    fail_d  = |((bus.cfifo_data[CHF_WIDTH-1:ADDR_WIDTH] ^ bus.rfifo_data) & mask_eff);
                    state_d = ST_WR_REC;
                end else if (stim_done && both_empty) begin
                    state_d = ST_WR_SUM;
                end
            end
            ST_WR_REC, ST_WR_SUM: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    w_d      = w_q + 2'd1;
                    if (w_q == LAST_W) begin
                        if (state_q == ST_WR_SUM) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_IDLE;
                            if (fail_q) fcnt_d = (&fcnt_q) ? fcnt_q : fcnt_q + 1'b1;
                            else        pass_d = (&pass_q) ? pass_q : pass_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (!stim_done) begin
                    wr_ptr_d = '0;
                    pass_d   = '0;
                    fcnt_d   = '0;
                    mask_d   = mask_ld ? bus.sc_data : '1;
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            w_q      <= '0;
            wr_ptr_q <= '0;
            act_q    <= '0;
            vaddr_q  <= '0;
            fail_q   <= 1'b0;
            pass_q   <= '0;
            fcnt_q   <= '0;
            mask_q   <= '1;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            wr_ptr_q <= wr_ptr_d;
            act_q    <= act_d;
            vaddr_q  <= vaddr_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
            fcnt_q   <= fcnt_d;
            mask_q   <= mask_d;
        end
    end

    rec_fmt u_rec_fmt (
        .state_i    (state_q),
        .w_i        (w_q),
        .fail_i     (fail_q),
        .act_i      (act_q),
        .vaddr_i    (vaddr_q),
        .fail_cnt_i (fcnt_q),
        .pass_cnt_i (pass_q),
        .wdata_o    (bus.mem_writedata)
    );

    assign bus.cfifo_rdreq    = pop;
    assign bus.rfifo_rdreq    = pop;
    assign bus.sc_ready       = (state_q == ST_IDLE);
    assign bus.mem_write      = (state_q == ST_WR_REC) || (state_q == ST_WR_SUM);
    assign bus.mem_address    = RES_BASE + wr_ptr_q;
    assign bus.mem_byteenable = '1;
    assign done               = (state_q == ST_DONE);
endmodule

// File: tb/tb_check.sv
// Randomised and directed bench for the result checker with a record-level model.
module tb_check;
    localparam logic [19:0] RES_BASE = 20'h80000;
    localparam int LOGSZ = 4096;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic stim_done = 1'b0;
    logic done;

    check_if bus ();
    check dut (.clock(clock), .reset_n(reset_n), .stim_done(stim_done), .done(done), .bus(bus));

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    int single_pops = 0;

    logic [43:0] cq[$];
    logic [23:0] rq[$];

    logic [19:0] log_addr[LOGSZ];
    logic [15:0] log_data[LOGSZ];
    int log_n = 0;
    logic [19:0] exp_addr[LOGSZ];
    logic [15:0] exp_data[LOGSZ];
    int exp_n = 0;
    int rd = 0;

    logic [23:0] m_mask;
    logic [19:0] m_ptr;
    int m_pass, m_fail;
    bit rand_wait = 1'b0;

    always @(negedge clock)
        if (reset_n && bus.mem_write && !bus.mem_waitrequest && log_n < LOGSZ) begin
            log_addr[log_n] = bus.mem_address;
            log_data[log_n] = bus.mem_writedata;
            log_n++;
        end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic refresh();
        bus.cfifo_rdempty = (cq.size() == 0);
        bus.cfifo_data    = (cq.size() != 0) ? cq[0] : '0;
        bus.rfifo_rdempty = (rq.size() == 0);
        bus.rfifo_data    = (rq.size() != 0) ? rq[0] : '0;
    endtask

    task automatic to_neg();
        @(negedge clock);
    endtask

    task automatic finish_cyc();
        bit pc, pr;
        pc = bus.cfifo_rdreq;
        pr = bus.rfifo_rdreq;
        if (pc != pr) single_pops++;
        @(posedge clock);
        #1;
        if (pc && cq.size() != 0) void'(cq.pop_front());
        if (pr && rq.size() != 0) void'(rq.pop_front());
        refresh();
        if (rand_wait) bus.mem_waitrequest = ($urandom_range(0, 3) == 0);
    endtask

    task automatic step();
        to_neg();
        finish_cyc();
    endtask

    task automatic add_word(input logic [15:0] d);
        exp_addr[exp_n] = RES_BASE + m_ptr;
        exp_data[exp_n] = d;
        exp_n++;
        m_ptr = m_ptr + 20'd1;
    endtask

    task automatic model_rec(input logic [23:0] e, input logic [23:0] a, input logic [19:0] va);
        bit f;
        f = ((e ^ a) & m_mask) != 0;
        add_word(16'((f ? 32'h8000 : 32'h0) + (a >> 16)));
        add_word(16'(a % 65536));
        add_word(16'(va >> 16));
        add_word(16'(va % 65536));
        if (f) m_fail = (m_fail < 65535) ? m_fail + 1 : m_fail;
        else   m_pass = (m_pass < 65535) ? m_pass + 1 : m_pass;
    endtask

    task automatic model_sum();
        add_word(16'hFFFF);
        add_word(16'(m_fail));
        add_word(16'(m_pass));
        add_word(16'h0000);
    endtask

    task automatic model_clear();
        m_ptr = '0;
        m_pass = 0;
        m_fail = 0;
        m_mask = '1;
    endtask

    task automatic push_pair(input logic [23:0] e, input logic [23:0] a, input logic [19:0] va, input int gap);
        cq.push_back({e, va});
        refresh();
        repeat (gap) step();
        rq.push_back(a);
        refresh();
        model_rec(e, a, va);
    endtask

    task automatic set_mask(input logic [23:0] m);
        bus.sc_cmd  = 5'b00001;
        bus.sc_data = m;
        step();
        bus.sc_cmd  = 5'b00000;
        m_mask = m;
    endtask

    task automatic drain(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            to_neg();
            ok = (cq.size() == 0) && (rq.size() == 0) && bus.sc_ready && (log_n >= exp_n);
            finish_cyc();
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            to_neg();
            ok = done && (log_n >= exp_n);
            finish_cyc();
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic compare_log();
        chk("word_count", 48'(log_n), 48'(exp_n));
        for (int i = rd; i < exp_n && i < log_n; i++) begin
            chk("rec_addr", log_addr[i], exp_addr[i]);
            chk("rec_data", log_data[i], exp_data[i]);
        end
        rd = log_n;
        exp_n = log_n;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t1w[4];
        logic [23:0] e, a;
        logic [19:0] va;
        int b, r0;
        t1w = '{16'h0012, 16'h3456, 16'h0000, 16'h0010};
        bus.sc_cmd = 5'b0;
        bus.sc_data = '0;
        bus.mem_waitrequest = 1'b0;
        model_clear();
        refresh();

        // Reset with a pair already waiting: no pop may happen while in reset.
        push_pair(24'h123456, 24'h123456, 20'h00010, 0);
        repeat (2) @(posedge clock);
        #1;
        to_neg();
        chk("rst_done", done, 0);
        chk("rst_cfifo_rdreq", bus.cfifo_rdreq, 0);
        chk("rst_rfifo_rdreq", bus.rfifo_rdreq, 0);
        chk("rst_sc_ready", bus.sc_ready, 1);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_address", bus.mem_address, RES_BASE);
        chk("rst_mem_writedata", bus.mem_writedata, 0);
        chk("rst_byteenable", bus.mem_byteenable, 2'b11);
        finish_cyc();
        reset_n = 1'b1;

        to_neg();
        chk("t1_pop_c", bus.cfifo_rdreq, 1);
        chk("t1_pop_r", bus.rfifo_rdreq, 1);
        finish_cyc();
        for (int k = 0; k < 4; k++) begin
            to_neg();
            chk("t1_write", bus.mem_write, 1);
            chk("t1_addr", bus.mem_address, RES_BASE + 20'(k));
            chk("t1_data", bus.mem_writedata, t1w[k]);
            finish_cyc();
        end
        to_neg();
        chk("t1_idle", bus.sc_ready, 1);
        chk("t1_write_low", bus.mem_write, 0);
        finish_cyc();
        compare_log();

        set_mask(24'hFFFF00);
        push_pair(24'hAAAA55, 24'hAAAA00, 20'h00020, 0);
        drain(100);
        chk("t2_pass_w0", log_data[4], 16'h00AA);
        set_mask(24'hFFFFFF);
        push_pair(24'hAAAA55, 24'hAAAA00, 20'h00020, 0);
        drain(100);
        chk("t2_fail_w0", log_data[8], 16'h80AA);
        compare_log();

        stim_done = 1'b1;
        model_sum();
        wait_done(100);
        chk("sum_done", done, 1);
        chk("sum_addr", log_addr[12], RES_BASE + 20'd12);
        chk("sum_w0", log_data[12], 16'hFFFF);
        chk("sum_w1", log_data[13], 16'h0001);
        chk("sum_w2", log_data[14], 16'h0002);
        chk("sum_w3", log_data[15], 16'h0000);
        compare_log();
        stim_done = 1'b0;
        step();
        to_neg();
        chk("clr_idle", bus.sc_ready, 1);
        chk("clr_done", done, 0);
        chk("clr_ptr", bus.mem_address, RES_BASE);
        finish_cyc();
        model_clear();

        // Only the result FIFO holds data: the checker must wait.
        rq.push_back(24'h0F0F0F);
        refresh();
        for (int i = 0; i < 10; i++) begin
            to_neg();
            chk("lone_rdreq", bus.cfifo_rdreq | bus.rfifo_rdreq, 0);
            chk("lone_write", bus.mem_write, 0);
            finish_cyc();
        end
        cq.push_back({24'h0F0F0F, 20'h00055});
        refresh();
        model_rec(24'h0F0F0F, 24'h0F0F0F, 20'h00055);
        to_neg();
        chk("lone_pop_c", bus.cfifo_rdreq, 1);
        chk("lone_pop_r", bus.rfifo_rdreq, 1);
        finish_cyc();
        drain(100);
        compare_log();

        // Three-cycle stall on the second word.
        push_pair(24'($urandom), 24'($urandom), 20'($urandom), 0);
        b = exp_n - 4;
        to_neg();
        chk("st_pop", bus.cfifo_rdreq, 1);
        finish_cyc();
        to_neg();
        chk("st_w0_addr", bus.mem_address, exp_addr[b]);
        chk("st_w0_data", bus.mem_writedata, exp_data[b]);
        finish_cyc();
        bus.mem_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            chk("st_hold_write", bus.mem_write, 1);
            chk("st_hold_addr", bus.mem_address, exp_addr[b+1]);
            chk("st_hold_data", bus.mem_writedata, exp_data[b+1]);
            finish_cyc();
        end
        bus.mem_waitrequest = 1'b0;
        for (int k = 1; k < 4; k++) begin
            to_neg();
            chk("st_busy", bus.sc_ready, 0);
            chk("st_addr", bus.mem_address, exp_addr[b+k]);
            chk("st_data", bus.mem_writedata, exp_data[b+k]);
            finish_cyc();
        end
        to_neg();
        chk("st_idle", bus.sc_ready, 1);
        finish_cyc();
        compare_log();

        // Random batches: random masks, mismatches, FIFO skew and stalls.
        rand_wait = 1'b1;
        for (int bt = 0; bt < 6; bt++) begin
            set_mask((bt == 0) ? 24'hFFFFFF : 24'($urandom));
            for (int p = 0; p < 8; p++) begin
                e  = 24'($urandom);
                a  = ($urandom_range(0, 2) == 0) ? e : (e ^ (24'h1 << $urandom_range(0, 23)));
                va = 20'($urandom);
                push_pair(e, a, va, $urandom_range(0, 1) ? $urandom_range(0, 4) : 0);
                repeat ($urandom_range(0, 6)) step();
            end
            drain(600);
            compare_log();
        end
        stim_done = 1'b1;
        model_sum();
        wait_done(200);
        compare_log();
        rand_wait = 1'b0;
        bus.mem_waitrequest = 1'b0;
        stim_done = 1'b0;
        step();
        step();
        model_clear();

        // Reset during the third word of a record; the queued pair survives.
        push_pair(24'h111111, 24'h111111, 20'h00AAA, 0);
        push_pair(24'h222222, 24'h222223, 20'h00BBB, 0);
        to_neg();
        chk("rm_pop", bus.cfifo_rdreq, 1);
        finish_cyc();
        step();
        step();
        chk("rm_in_record", bus.mem_write, 1);
        reset_n = 1'b0;
        #1;
        chk("rm_mem_write", bus.mem_write, 0);
        chk("rm_addr", bus.mem_address, RES_BASE);
        chk("rm_data", bus.mem_writedata, 0);
        chk("rm_sc_ready", bus.sc_ready, 1);
        chk("rm_rdreq", bus.cfifo_rdreq, 0);
        chk("rm_done", done, 0);
        rd = log_n;
        exp_n = log_n;
        r0 = log_n;
        model_clear();
        model_rec(24'h222222, 24'h222223, 20'h00BBB);
        step();
        reset_n = 1'b1;
        drain(100);
        chk("rm_restart_addr", log_addr[r0], RES_BASE);
        compare_log();

        chk("lockstep_pop", 48'(single_pops), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
